// File: rtl/countdown_fsm_pkg.sv
// Shared timer definitions: state encodings, default width and the
// prescaler width helper used by the countdown timer.
package countdown_fsm_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Counter width able to hold 0..p-1, never narrower than one bit.
  function automatic int prescale_width(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/countdown_fsm_prescaler.sv
// Free-running divide-by-PRESCALE tick generator for the countdown timer.
// Holds its count while disabled so a paused timer resumes mid-period.
module countdown_fsm_prescaler
  import countdown_fsm_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_fsm.sv
// Programmable down-counting timer with pause/resume and periodic reload;
// raises a one-cycle expired pulse when the count runs out.
module countdown_fsm
  import countdown_fsm_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             start,
  input  logic             stop,
  input  logic             reload_en,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [1:0]       state, state_next;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic [WIDTH-1:0] eff;
  logic             expired_next;
  logic             tick;
  logic             pre_en;
  logic             pre_clr;

  assign busy   = (state == ST_RUN);
  assign pre_en = busy && !stop;
  assign eff    = ld ? in : out;

  countdown_fsm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pre_en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    out_next     = out;
    reload_next  = reload_reg;
    expired_next = 1'b0;
    pre_clr      = 1'b0;

    case (state)
      ST_RUN: begin
        if (stop) begin
          state_next = ST_PAUSE;
        end else if (tick) begin
          if (out > ONE) begin
            out_next = out - ONE;
          end else begin
            expired_next = 1'b1;
            if (reload_en) begin
              out_next = reload_reg;
            end else begin
              out_next   = '0;
              state_next = ST_DONE;
            end
          end
        end
      end

      default: begin
        if (ld) begin
          out_next    = in;
          reload_next = in;
        end
        // A zero effective count would expire without ever ticking, so it
        // never enters RUN; a paused timer also stays put while stop is held.
        if (start && (eff != '0) && !((state == ST_PAUSE) && stop)) begin
          state_next = ST_RUN;
          pre_clr    = (state != ST_PAUSE);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      out        <= '0;
      reload_reg <= '0;
      expired    <= 1'b0;
    end else begin
      state      <= state_next;
      out        <= out_next;
      reload_reg <= reload_next;
      expired    <= expired_next;
    end
  end

endmodule

// File: tb/tb_countdown_fsm.sv
// Self-checking bench: a PRESCALE=1 and a PRESCALE=4 timer driven by
// directed vectors, each compared every cycle against a behavioural model.
module tb_countdown_fsm;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] ld, start, stop, reload_en;
  logic [7:0] in_v  [2];
  logic [7:0] out_v [2];
  logic [1:0] busy, expired;

  int m_state [2];
  int m_out   [2];
  int m_rel   [2];
  int m_pre   [2];
  int m_exp   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  countdown_fsm #(.WIDTH(8), .PRESCALE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .ld(ld[0]), .in(in_v[0]), .start(start[0]),
    .stop(stop[0]), .reload_en(reload_en[0]), .out(out_v[0]),
    .busy(busy[0]), .expired(expired[0])
  );

  countdown_fsm #(.WIDTH(8), .PRESCALE(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ld(ld[1]), .in(in_v[1]), .start(start[1]),
    .stop(stop[1]), .reload_en(reload_en[1]), .out(out_v[1]),
    .busy(busy[1]), .expired(expired[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-level timer behaviour: a countdown value, a phase within the
  // current tick period, and a mode that gates whether time advances.
  task automatic model_step(input int k);
    int st, o, r, p, e, last, eff;
    st   = m_state[k];
    o    = m_out[k];
    r    = m_rel[k];
    p    = m_pre[k];
    e    = 0;
    last = (k == 0) ? 0 : 3;
    eff  = ld[k] ? int'(in_v[k]) : o;
    if (st == M_RUN) begin
      if (stop[k]) begin
        st = M_PAUSE;
      end else if (p == last) begin
        p = 0;
        if (o > 1) begin
          o = o - 1;
        end else begin
          e = 1;
          if (reload_en[k]) o = r;
          else begin
            o  = 0;
            st = M_DONE;
          end
        end
      end else begin
        p = p + 1;
      end
    end else begin
      if (ld[k]) begin
        o = int'(in_v[k]);
        r = o;
      end
      if (start[k] && eff != 0 && !(st == M_PAUSE && stop[k])) begin
        if (st != M_PAUSE) p = 0;
        st = M_RUN;
      end
    end
    m_state[k] <= st;
    m_out[k]   <= o;
    m_rel[k]   <= r;
    m_pre[k]   <= p;
    m_exp[k]   <= e;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_state[k] <= M_IDLE;
        m_out[k]   <= 0;
        m_rel[k]   <= 0;
        m_pre[k]   <= 0;
        m_exp[k]   <= 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("model_out%0d", k), int'(out_v[k]), m_out[k]);
      check($sformatf("model_busy%0d", k), int'(busy[k]), int'(m_state[k] == M_RUN));
      check($sformatf("model_expired%0d", k), int'(expired[k]), m_exp[k]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic expect_k(input string name, input int k, input int o, input int b, input int e);
    check($sformatf("%s_out%0d", name, k), int'(out_v[k]), o);
    check($sformatf("%s_busy%0d", name, k), int'(busy[k]), b);
    check($sformatf("%s_expired%0d", name, k), int'(expired[k]), e);
  endtask

  initial begin
    rst_n     = 1'b0;
    ld        = '0;
    start     = '0;
    stop      = '0;
    reload_en = '0;
    in_v[0]   = '0;
    in_v[1]   = '0;
    cycles(2);
    rst_n = 1'b1;
    cyc();
    expect_k("reset", 0, 0, 0, 0);
    expect_k("reset", 1, 0, 0, 0);

    // start with out=0 and no load is ignored
    start = 2'b11;
    cyc();
    start = 2'b00;
    expect_k("start_zero", 0, 0, 0, 0);
    expect_k("start_zero", 1, 0, 0, 0);

    // one-shot, PRESCALE=1, in=3
    ld[0] = 1'b1; in_v[0] = 8'd3;
    cyc();
    ld[0] = 1'b0;
    expect_k("os_load", 0, 3, 0, 0);
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    expect_k("os_e0", 0, 3, 1, 0);
    cyc(); expect_k("os_e1", 0, 2, 1, 0);
    cyc(); expect_k("os_e2", 0, 1, 1, 0);
    cyc(); expect_k("os_e3", 0, 0, 0, 1);
    cyc(); expect_k("os_e4", 0, 0, 0, 0);

    // prescaled, PRESCALE=4, ld+start in=2
    ld[1] = 1'b1; start[1] = 1'b1; in_v[1] = 8'd2;
    cyc();
    ld[1] = 1'b0; start[1] = 1'b0;
    expect_k("ps_e0", 1, 2, 1, 0);
    cycles(3); expect_k("ps_e3", 1, 2, 1, 0);
    cyc();     expect_k("ps_e4", 1, 1, 1, 0);
    cycles(3); expect_k("ps_e7", 1, 1, 1, 0);
    cyc();     expect_k("ps_e8", 1, 0, 0, 1);

    // pause at prescaler=2 for 10 cycles, then resume, PRESCALE=4, in=5
    ld[1] = 1'b1; start[1] = 1'b1; in_v[1] = 8'd5;
    cyc();
    ld[1] = 1'b0; start[1] = 1'b0;
    cycles(2);
    stop[1] = 1'b1;
    cycles(10);
    expect_k("pause_hold", 1, 5, 0, 0);
    stop[1] = 1'b0; start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    expect_k("resume_r0", 1, 5, 1, 0);
    cyc();      expect_k("resume_r1", 1, 5, 1, 0);
    cyc();      expect_k("resume_r2", 1, 4, 1, 0);
    cycles(15); expect_k("resume_r17", 1, 1, 1, 0);
    cyc();      expect_k("resume_r18", 1, 0, 0, 1);

    // periodic, PRESCALE=1, in=4
    reload_en[0] = 1'b1; ld[0] = 1'b1; start[0] = 1'b1; in_v[0] = 8'd4;
    cyc();
    ld[0] = 1'b0; start[0] = 1'b0;
    expect_k("per_e0", 0, 4, 1, 0);
    cycles(3); expect_k("per_e3", 0, 1, 1, 0);
    cyc();     expect_k("per_e4", 0, 4, 1, 1);
    cyc();     expect_k("per_e5", 0, 3, 1, 0);
    cycles(3); expect_k("per_e8", 0, 4, 1, 1);
    reload_en[0] = 1'b0;
    cycles(3); expect_k("per_e11", 0, 1, 1, 0);
    cyc();     expect_k("per_e12", 0, 0, 0, 1);

    // ld during RUN is ignored
    ld[1] = 1'b1; start[1] = 1'b1; in_v[1] = 8'd3;
    cyc();
    ld[1] = 1'b0; start[1] = 1'b0;
    cyc();
    ld[1] = 1'b1; in_v[1] = 8'd9;
    cyc();
    ld[1] = 1'b0;
    expect_k("ld_in_run", 1, 3, 1, 0);
    cycles(2); expect_k("ld_in_run_e4", 1, 2, 1, 0);

    // start+stop in PAUSE keeps PAUSE
    stop[1] = 1'b1;
    cyc();
    expect_k("stop_pause", 1, 2, 0, 0);
    start[1] = 1'b1;
    cycles(3);
    expect_k("start_stop_pause", 1, 2, 0, 0);
    stop[1] = 1'b0;
    cyc();
    start[1] = 1'b0;
    expect_k("pause_resume", 1, 2, 1, 0);

    // asynchronous reset mid-count with out=5
    stop[1] = 1'b1;
    cyc();
    stop[1] = 1'b0; ld[1] = 1'b1; in_v[1] = 8'd5;
    cyc();
    ld[1] = 1'b0; start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    cyc();
    expect_k("pre_reset", 1, 5, 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    expect_k("async_reset", 1, 0, 0, 0);
    expect_k("async_reset", 0, 0, 0, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    expect_k("post_reset", 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
